// File: rtl/r16_stage_sched_pkg.sv
// r16_stage_sched_pkg: shared state encoding and default sizing for the radix-16 stage sequencer.
package r16_stage_sched_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_NUM_STG  = 4;
    localparam int DEF_STG_W    = 2;
    localparam int DEF_PIPE_LAT = 3;
    localparam int D_WIDTH      = 32;
endpackage

// File: rtl/r16_beat_tracker.sv
// r16_beat_tracker: PIPE_LAT-deep valid/address/stage delay line mirroring the butterfly datapath.
module r16_beat_tracker
    import r16_stage_sched_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int STG_W    = DEF_STG_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [STG_W-1:0]  stg_idx_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [STG_W-1:0]  wr_stg_o,
    output logic              pipe_empty_o
);
    logic [PIPE_LAT-1:0]             vld_q;
    logic [PIPE_LAT-1:0][ADDR_W-1:0] addr_q;
    logic [PIPE_LAT-1:0][STG_W-1:0]  stg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            addr_q <= '0;
            stg_q  <= '0;
        end else begin
            vld_q  <= {vld_q[PIPE_LAT-2:0], rd_en_i};
            addr_q <= {addr_q[PIPE_LAT-2:0], rd_addr_i};
            stg_q  <= {stg_q[PIPE_LAT-2:0], stg_idx_i};
        end
    end

    assign wr_en_o   = vld_q[PIPE_LAT-1];
    assign wr_addr_o = addr_q[PIPE_LAT-1];
    assign wr_stg_o  = stg_q[PIPE_LAT-1];
    // Nothing behind the output tap: the beat leaving now is the last one in flight.
    assign pipe_empty_o = ~|vld_q[PIPE_LAT-2:0];
endmodule

// File: rtl/r16_stage_sched.sv
// r16_stage_sched: per-stage read/write-back sequencer for one radix-16 butterfly engine.
module r16_stage_sched
    import r16_stage_sched_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_STG  = DEF_NUM_STG,
    parameter int STG_W    = DEF_STG_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [STG_W-1:0]  stg_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [STG_W-1:0]  wr_stg,
    output logic              busy,
    output logic              done
);
    state_e            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [STG_W-1:0]  stg_q;
    logic              pipe_empty;

    assign rd_en   = (state_q == RUN) && !hold;
    assign rd_addr = rd_addr_q;
    assign stg_idx = stg_q;
    assign busy    = state_q != IDLE;
    assign done    = state_q == FIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            stg_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_q   <= RUN;
                    rd_addr_q <= '0;
                    stg_q     <= '0;
                end
                RUN: if (rd_en) begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    if (&rd_addr_q) state_q <= DRAIN;
                end
                // Next stage reads only once the last write-back of this stage leaves.
                DRAIN: if (pipe_empty) begin
                    if (stg_q == STG_W'(NUM_STG - 1)) state_q <= FIN;
                    else begin
                        stg_q   <= stg_q + 1'b1;
                        state_q <= RUN;
                    end
                end
                FIN: state_q <= IDLE;
            endcase
        end
    end

    r16_beat_tracker #(
        .ADDR_W  (ADDR_W),
        .STG_W   (STG_W),
        .PIPE_LAT(PIPE_LAT)
    ) u_trk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr_q),
        .stg_idx_i   (stg_q),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_stg_o    (wr_stg),
        .pipe_empty_o(pipe_empty)
    );
endmodule

// File: tb/tb_r16_stage_sched.sv
// tb_r16_stage_sched: scoreboard bench; a small instance is checked cycle-exactly against a timeline
// model, a default-size instance is checked for full-transform beat ordering and counts.
module tb_r16_stage_sched;
    localparam int SN = 4, SS = 2, SL = 3, BIG = 1 << 30;

    typedef struct { int cyc; int addr; int stg; } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n_s = 1'b0, start_s = 1'b0, hold_s = 1'b0;
    logic       rd_en_s, wr_en_s, busy_s, done_s;
    logic [1:0] rd_addr_s, wr_addr_s;
    logic [0:0] stg_s, wr_stg_s;

    logic        rst_n_b = 1'b0, start_b = 1'b0, hold_b = 1'b0;
    logic        rd_en_b, wr_en_b, busy_b, done_b;
    logic [11:0] rd_addr_b, wr_addr_b;
    logic [1:0]  stg_b, wr_stg_b;

    r16_stage_sched #(.ADDR_W(2), .NUM_STG(SS), .STG_W(1), .PIPE_LAT(SL)) dut_s (
        .clk(clk), .rst_n(rst_n_s), .start(start_s), .hold(hold_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .stg_idx(stg_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_stg(wr_stg_s),
        .busy(busy_s), .done(done_s)
    );

    r16_stage_sched dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .hold(hold_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .stg_idx(stg_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_stg(wr_stg_b),
        .busy(busy_b), .done(done_b)
    );

    int errors = 0, checks = 0;
    beat_t rq[$], wq[$];
    int busy_from = 0, idle_from = BIG, ready = BIG, done_cyc = -1, m_stg = 0, m_addr = 0;
    int s0_cyc = -1, s1_cyc = -1, dn_cyc = -1, dn_cnt = 0;
    int rd_cnt_b = 0, wr_cnt_b = 0, dn_cnt_b = 0, last_wr_b = -1;
    int bq[$];
    bit big_stop = 0;

    function automatic void chk(string n, longint a, longint e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
        end
    endfunction

    // Timeline model: reads open one cycle after start and one cycle after a stage's last write.
    function automatic void model_step(bit st, bit hd);
        if (cyc >= idle_from && st) begin
            busy_from = cyc + 1; idle_from = BIG; ready = cyc + 1; m_stg = 0; m_addr = 0;
        end else if (cyc >= ready && !hd) begin
            rq.push_back('{cyc, m_addr, m_stg});
            wq.push_back('{cyc + SL, m_addr, m_stg});
            m_addr++;
            if (m_addr == SN) begin
                m_addr = 0;
                if (m_stg == SS - 1) begin
                    done_cyc = cyc + SL + 1; idle_from = cyc + SL + 2; ready = BIG;
                end else begin
                    m_stg++; ready = cyc + SL + 1;
                end
            end
        end
    endfunction

    task automatic tick(input bit st, input bit hd);
        start_s = st; hold_s = hd;
        model_step(st, hd);
        @(posedge clk); #1;
    endtask

    task automatic run_idle(input int n);
        repeat (n) tick(0, 0);
    endtask

    task automatic do_reset(input int n);
        start_s = 0; hold_s = 0;
        #1 rst_n_s = 0;
        rq.delete(); wq.delete();
        done_cyc = -1; busy_from = 0; idle_from = BIG; ready = BIG;
        #1 chk("rst_async", {rd_en_s, rd_addr_s, stg_s, wr_en_s, wr_addr_s, wr_stg_s, busy_s, done_s}, 0);
        repeat (n) @(posedge clk);
        #1 rst_n_s = 1; idle_from = cyc;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n_s)
            chk("rst_zero", {rd_en_s, rd_addr_s, stg_s, wr_en_s, wr_addr_s, wr_stg_s, busy_s, done_s}, 0);
        else begin
            if (rd_en_s) begin
                if (rq.size() == 0 || rq[0].cyc != cyc) chk("rd_unexpected", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("rd_addr", rd_addr_s, e.addr);
                    chk("rd_stg", stg_s, e.stg);
                end
                if (rd_addr_s == 0) begin
                    if (stg_s == 0) s0_cyc = cyc;
                    else s1_cyc = cyc;
                end
            end else if (rq.size() != 0 && rq[0].cyc == cyc) begin
                chk("rd_missing", 0, 1);
                void'(rq.pop_front());
            end
            if (wr_en_s) begin
                if (wq.size() == 0 || wq[0].cyc != cyc) chk("wr_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_addr", wr_addr_s, e.addr);
                    chk("wr_stg", wr_stg_s, e.stg);
                end
            end else if (wq.size() != 0 && wq[0].cyc == cyc) begin
                chk("wr_missing", 0, 1);
                void'(wq.pop_front());
            end
            chk("done", done_s, cyc == done_cyc);
            chk("busy", busy_s, cyc >= busy_from && cyc < idle_from);
            if (done_s) begin dn_cnt++; dn_cyc = cyc; end
        end
        if (rst_n_b) begin
            if (rd_en_b) begin
                chk("big_rd_seq", {stg_b, rd_addr_b}, rd_cnt_b % 16384);
                rd_cnt_b++;
                bq.push_back(cyc + 3);
            end
            if (wr_en_b) begin
                chk("big_wr_seq", {wr_stg_b, wr_addr_b}, wr_cnt_b % 16384);
                wr_cnt_b++;
                if (bq.size() == 0) chk("big_wr_unexpected", 1, 0);
                else chk("big_wr_lat", cyc, bq.pop_front());
                last_wr_b = cyc;
            end
            if (done_b) begin
                dn_cnt_b++;
                chk("big_done_t", cyc, last_wr_b + 1);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n_b = 1; start_b = 1;
        @(posedge clk); #1 start_b = 0;
        while (!big_stop) begin
            hold_b = $urandom_range(0, 7) == 0;
            @(posedge clk); #1;
        end
    end

    initial begin
        int c0, n;
        repeat (3) @(posedge clk);
        #1 rst_n_s = 1; idle_from = cyc;
        run_idle(2);

        c0 = cyc; tick(1, 0); run_idle(20);
        chk("basic_s0", s0_cyc - c0, 1);
        chk("basic_s1", s1_cyc - c0, 8);
        chk("basic_done", dn_cyc - c0, 15);

        c0 = cyc; tick(1, 0); tick(0, 0); tick(0, 1); tick(0, 1); run_idle(20);
        chk("hold_s1", s1_cyc - c0, 10);
        chk("hold_done", dn_cyc - c0, 17);

        c0 = cyc; n = dn_cnt;
        for (int i = 0; i < 20; i++) tick(i == 0 || i == 5 || i == 15, 0);
        run_idle(4);
        chk("busy_start_dones", dn_cnt - n, 1);
        chk("busy_start_done_t", dn_cyc - c0, 15);

        n = dn_cnt; tick(1, 0); run_idle(5); do_reset(2); run_idle(20);
        chk("rst_no_done", dn_cnt - n, 0);
        c0 = cyc; tick(1, 0); run_idle(20);
        chk("rst_rerun_s0", s0_cyc - c0, 1);
        chk("rst_rerun_done", dn_cyc - c0, 15);

        c0 = cyc; tick(1, 0); run_idle(15); tick(1, 0); run_idle(20);
        chk("b2b_s0", s0_cyc - c0, 17);
        chk("b2b_done", dn_cyc - c0, 31);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(2);
            else tick($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end
        run_idle(30);

        for (int i = 0; i < 40000 && dn_cnt_b == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        chk("big_done_cnt", dn_cnt_b, 1);
        chk("big_rd_cnt", rd_cnt_b, 16384);
        chk("big_wr_cnt", wr_cnt_b, 16384);
        big_stop = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/r16_stage_sched.md
Name: r16_stage_sched

Overview:
- Sequencer for one radix-16 butterfly engine of the 65536-point pipeline. The engine consumes 16 samples per beat through the 2-register input delay and butterfly.
- Per FFT stage, it issues read beats to the in-place sample memory and tracks each beat through the fixed-latency datapath. It issues the matching write-back beats.
- It drains the pipeline before starting the next stage, which prevents read-after-write hazards on the in-place memory.
- It signals completion after the last stage.

Parameters:
- ADDR_W, 12: group address width; one stage is 2^ADDR_W beats (4096 groups x 16 samples = 65536).
- NUM_STG, 4: number of radix-16 stages per transform (16^4 = 65536).
- STG_W, 2: stage index width; must satisfy 2^STG_W >= NUM_STG.
- PIPE_LAT, 3: cycles from a read beat to its write beat (input delay 2 + butterfly 1); legal range 2..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE, ignored otherwise
- hold  in  1  read-side back-pressure; suppresses read beats, does not stall the datapath
- rd_en  out  1  read beat valid this cycle
- rd_addr  out  ADDR_W  group address of the read beat
- stg_idx  out  STG_W  current stage; selects twiddle set and address permutation
- wr_en  out  1  write-back beat valid this cycle
- wr_addr  out  ADDR_W  group address of the write beat (rd_addr delayed PIPE_LAT)
- wr_stg  out  STG_W  stage of the write beat
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse when the transform completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0, all state registers, the valid/address/stage shift registers and every output are 0, and the FSM is in IDLE.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE -> RUN when start=1. rd_addr=0, stg_idx=0.
  - RUN: rd_en = ~hold (combinational from state and hold).
    - On each rd_en beat, rd_addr increments.
    - On the beat with rd_addr = 2^ADDR_W-1, go to DRAIN. rd_addr wraps to 0.
  - DRAIN: rd_en=0. Wait until the last write beat of the stage is issued.
    - If stg_idx < NUM_STG-1: stg_idx++ and return to RUN.
    - Otherwise go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Timing:
  - The first rd_en is the cycle after start is sampled.
  - A read beat in cycle c produces wr_en in cycle c+PIPE_LAT, with wr_addr = rd_addr and wr_stg = stg_idx of cycle c.
  - Beats issued under hold gaps keep their gaps on the write side. Order is preserved.
  - The first rd_en of stage s+1 occurs exactly 1 cycle after the last wr_en of stage s. There are no overlapping beats across stages.
  - done is asserted the cycle after the final wr_en.
- busy: 1 in RUN, DRAIN and FIN; 0 in IDLE. It falls the cycle after done.
- Datapath tracking: a valid shift register of depth PIPE_LAT, plus parallel address and stage shift registers. It shifts every cycle regardless of hold. wr_en is the last valid tap.
- Boundary conditions:
  - hold is held high for the whole of RUN: no reads, no progress, no timeout.
  - hold during DRAIN or IDLE has no effect.
  - start while busy is ignored. It is neither queued nor restarts the transform.
  - start in the same cycle as FIN is ignored; start is accepted from IDLE on the next cycle.
  - rst_n asserted mid-transform: all in-flight write beats are discarded and no done is issued. After release the block sits in IDLE.
  - ADDR_W=1: one full-range rd_addr step per stage still terminates correctly.

Decomposition:
- Shared package/define file holds:
  - state encoding localparams (IDLE=0, RUN=1, DRAIN=2, FIN=3);
  - default ADDR_W/NUM_STG/PIPE_LAT;
  - data width D_width, kept in the existing define file.
- One natural sub-module: r16_beat_tracker. It is the PIPE_LAT-deep valid/address/stage shift register, with async reset. It outputs wr_en/wr_addr/wr_stg and a pipe_empty flag for the DRAIN exit.

Test Plan:
- Basic run: ADDR_W=2, NUM_STG=2, PIPE_LAT=3, start pulse at cycle 0.
  - rd_en cycles 1-4, addr 0..3, stg 0; wr_en cycles 4-7, addr 0..3.
  - rd_en cycles 8-11, stg 1; wr_en cycles 11-14.
  - done at cycle 15; busy 1 over cycles 1-15.
- Hold gaps: same config, hold=1 in cycles 2-3.
  - Reads at cycles 1,4,5,6 (addr 0..3); writes at cycles 4,7,8,9 with the same addresses.
  - Stage 1 first read at cycle 10.
- Start while busy: start pulsed again at cycles 5 and 15 → ignored; exactly one done, timing identical to the basic run.
- Reset mid-operation: rst_n low at cycle 6 for 2 cycles.
  - All outputs 0 immediately (asynchronous).
  - No wr_en or done afterwards.
  - A new start runs the basic sequence from addr 0, stg 0.
- Back-to-back transforms: start at cycle 16, immediately after done at 15 → rd_en at cycle 17, addr 0, stg 0.
- Default parameters: one start → exactly 4x4096 rd_en and 4x4096 wr_en beats; each stage's addresses 0..4095 in order; one done.
